// File: rtl/mips_alu_pkg.sv
// Shared encodings for the EX-stage ALU control decoder and the HI/LO multiply/divide sequencer.
package mips_alu_pkg;

    typedef enum logic [3:0] {
        ALU_AND     = 4'b0000,
        ALU_OR      = 4'b0001,
        ALU_ADD     = 4'b0010,
        ALU_XOR     = 4'b0011,
        ALU_SUB     = 4'b0110,
        ALU_SLT     = 4'b0111,
        ALU_SLTU    = 4'b1000,
        ALU_NOR     = 4'b1100,
        ALU_INVALID = 4'b1111
    } alu_ctrl_e;

    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_ADDU  = 6'b100001;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_SUBU  = 6'b100011;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_XOR   = 6'b100110;
    localparam logic [5:0] F_NOR   = 6'b100111;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_SLTU  = 6'b101011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    typedef enum logic [1:0] {
        MD_IDLE  = 2'b00,
        MD_MUL   = 2'b01,
        MD_DIV   = 2'b10,
        MD_FIXUP = 2'b11
    } md_state_e;

endpackage

// File: rtl/mips_muldiv_seq.sv
// Iterative 1-bit/cycle multiply (shift-add) and divide (restoring) engine owning HI/LO.
module mips_muldiv_seq
    import mips_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             op_div_i,
    input  logic             op_unsigned_i,
    input  logic             flush_i,
    input  logic             wr_hi_i,
    input  logic             wr_lo_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic [WIDTH-1:0] src_a_i,
    input  logic [WIDTH-1:0] src_b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    md_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic               divz_q, divz_d;
    logic               is_div_q, is_div_d;
    logic               done_q, done_d;

    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH+1:0]   div_trial;
    logic               div_ok;
    logic [WIDTH-1:0]   div_rem;

    assign mag_a = (~op_unsigned_i & src_a_i[WIDTH-1]) ? -src_a_i : src_a_i;
    assign mag_b = (~op_unsigned_i & src_b_i[WIDTH-1]) ? -src_b_i : src_b_i;

    // acc holds {partial_product_hi, multiplier} for MUL and {remainder, quotient} for DIV
    assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opb_q : '0)};
    assign div_trial = {1'b0, acc_q[2*WIDTH-1:WIDTH-1]} - {2'b00, opb_q};
    assign div_ok    = ~div_trial[WIDTH+1];
    assign div_rem   = div_ok ? div_trial[WIDTH-1:0] : acc_q[2*WIDTH-2:WIDTH-1];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opb_d     = opb_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        divz_d    = divz_q;
        is_div_d  = is_div_q;
        done_d    = 1'b0;
        unique case (state_q)
            MD_IDLE: begin
                if (wr_hi_i) hi_d = wr_data_i;
                if (wr_lo_i) lo_d = wr_data_i;
                if (start_i) begin
                    cnt_d     = '0;
                    is_div_d  = op_div_i;
                    neg_res_d = ~op_unsigned_i & (src_a_i[WIDTH-1] ^ src_b_i[WIDTH-1]);
                    neg_rem_d = ~op_unsigned_i & src_a_i[WIDTH-1];
                    divz_d    = (src_b_i == '0);
                    if (op_div_i) begin
                        state_d = MD_DIV;
                        acc_d   = {{WIDTH{1'b0}}, mag_a};
                        opb_d   = mag_b;
                    end else begin
                        state_d = MD_MUL;
                        acc_d   = {{WIDTH{1'b0}}, mag_b};
                        opb_d   = mag_a;
                    end
                end
            end
            MD_MUL: begin
                acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = MD_FIXUP;
                end
            end
            MD_DIV: begin
                acc_d = {div_rem, acc_q[WIDTH-2:0], div_ok};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = MD_FIXUP;
                end
            end
            MD_FIXUP: begin
                state_d = MD_IDLE;
                done_d  = 1'b1;
                if (is_div_q) begin
                    hi_d = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
                    lo_d = divz_q ? '1 : (neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
                end else begin
                    {hi_d, lo_d} = neg_res_q ? -acc_q : acc_q;
                end
            end
            default: state_d = MD_IDLE;
        endcase
        // A flush abandons the operation, including the FIXUP write-back
        if (flush_i && (state_q != MD_IDLE)) begin
            state_d = MD_IDLE;
            cnt_d   = '0;
            done_d  = 1'b0;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= MD_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opb_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            divz_q    <= 1'b0;
            is_div_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opb_q     <= opb_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            divz_q    <= divz_d;
            is_div_q  <= is_div_d;
            done_q    <= done_d;
        end
    end

    assign busy_o = (state_q != MD_IDLE);
    assign done_o = done_q;
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

endmodule

// File: rtl/mips_alu_ctrl_md.sv
// EX-stage ALU control decode plus HI/LO access and mul/div issue/stall control.
module mips_alu_ctrl_md
    import mips_alu_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid,
    input  logic [1:0]        alu_op,
    input  logic [5:0]        instr_funct,
    input  logic              flush,
    input  logic [WIDTH-1:0]  src_a,
    input  logic [WIDTH-1:0]  src_b,
    output logic [CTRL_W-1:0] alu_control,
    output logic              illegal_funct,
    output logic [WIDTH-1:0]  md_result,
    output logic              md_stall,
    output logic              md_busy,
    output logic              md_done,
    output logic [WIDTH-1:0]  hi,
    output logic [WIDTH-1:0]  lo
);

    alu_ctrl_e ctrl;
    logic      illegal;
    logic      md_class;
    logic      is_muldiv;
    logic      accept;
    logic      seq_start;
    logic      wr_hi;
    logic      wr_lo;

    always_comb begin
        ctrl     = ALU_ADD;
        illegal  = 1'b0;
        md_class = 1'b0;
        if (!alu_op[1]) begin
            ctrl = alu_op[0] ? ALU_SUB : ALU_ADD;
        end else begin
            case (instr_funct)
                F_ADD, F_ADDU:   ctrl = ALU_ADD;
                F_SUB, F_SUBU:   ctrl = ALU_SUB;
                F_AND:           ctrl = ALU_AND;
                F_OR:            ctrl = ALU_OR;
                F_XOR:           ctrl = ALU_XOR;
                F_NOR:           ctrl = ALU_NOR;
                F_SLT:           ctrl = ALU_SLT;
                F_SLTU:          ctrl = ALU_SLTU;
                F_MULT, F_MULTU, F_DIV, F_DIVU,
                F_MFHI, F_MFLO, F_MTHI, F_MTLO: begin
                    ctrl     = ALU_ADD;
                    md_class = 1'b1;
                end
                default: begin
                    ctrl    = ALU_INVALID;
                    illegal = 1'b1;
                end
            endcase
        end
    end

    assign alu_control   = CTRL_W'(ctrl);
    assign illegal_funct = illegal;

    // mult/multu/div/divu share funct[5:2]=0110; funct[1] selects divide, funct[0] unsigned
    assign is_muldiv = (instr_funct[5:2] == 4'b0110);
    assign accept    = valid & md_class & ~md_busy & ~flush;
    assign seq_start = accept & is_muldiv;
    assign wr_hi     = accept & (instr_funct == F_MTHI);
    assign wr_lo     = accept & (instr_funct == F_MTLO);
    assign md_stall  = valid & md_class & md_busy;

    always_comb begin
        md_result = '0;
        if (alu_op[1] && (instr_funct == F_MFHI)) md_result = hi;
        else if (alu_op[1] && (instr_funct == F_MFLO)) md_result = lo;
    end

    mips_muldiv_seq #(
        .WIDTH(WIDTH)
    ) u_seq (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (seq_start),
        .op_div_i     (instr_funct[1]),
        .op_unsigned_i(instr_funct[0]),
        .flush_i      (flush),
        .wr_hi_i      (wr_hi),
        .wr_lo_i      (wr_lo),
        .wr_data_i    (src_a),
        .src_a_i      (src_a),
        .src_b_i      (src_b),
        .busy_o       (md_busy),
        .done_o       (md_done),
        .hi_o         (hi),
        .lo_o         (lo)
    );

endmodule

// File: tb/tb_mips_alu_ctrl_md.sv
// Bench for mips_alu_ctrl_md: decode vector table plus scoreboarded mul/div sequences.
module tb_mips_alu_ctrl_md;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid;
    logic [1:0]  alu_op;
    logic [5:0]  instr_funct;
    logic        flush;
    logic [31:0] src_a, src_b;
    logic [3:0]  alu_control;
    logic        illegal_funct;
    logic [31:0] md_result;
    logic        md_stall, md_busy, md_done;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0] op;
        logic [5:0] funct;
        logic [3:0] exp_ctrl;
        logic       exp_ill;
    } dec_vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        string       name;
    } exp_t;

    exp_t sb[$];

    mips_alu_ctrl_md #(.WIDTH(32), .CTRL_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .valid(valid), .alu_op(alu_op),
        .instr_funct(instr_funct), .flush(flush), .src_a(src_a), .src_b(src_b),
        .alu_control(alu_control), .illegal_funct(illegal_funct),
        .md_result(md_result), .md_stall(md_stall), .md_busy(md_busy),
        .md_done(md_done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", nm, got, exp);
        end
    endtask

    task automatic pop_check();
        exp_t e;
        if (sb.size() == 0) begin
            chk("scoreboard empty", 64'd0, 64'd1);
        end else begin
            e = sb.pop_front();
            chk({e.name, " hi"}, 64'(hi), 64'(e.hi));
            chk({e.name, " lo"}, 64'(lo), 64'(e.lo));
        end
    endtask

    // Call at posedge+1; returns at posedge+1 of the md_done cycle
    task automatic run_md(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el, input string nm);
        exp_t e;
        int   busy_n;
        bit   seen;
        e.hi = eh; e.lo = el; e.name = nm;
        valid = 1'b1; alu_op = 2'b10; instr_funct = f; src_a = a; src_b = b; flush = 1'b0;
        sb.push_back(e);
        @(posedge clk); #1;
        valid = 1'b0;
        busy_n = 0; seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (md_done) begin
                seen = 1'b1;
                break;
            end
            if (md_busy) busy_n++;
            @(posedge clk); #1;
        end
        chk({nm, " done seen"}, 64'(seen), 64'd1);
        chk({nm, " busy cycles"}, 64'(busy_n), 64'd33);
        chk({nm, " busy at done"}, 64'(md_busy), 64'd0);
        if (seen) pop_check();
        else void'(sb.pop_back());
    endtask

    initial begin
        dec_vec_t    vecs[14];
        logic [31:0] old_hi, old_lo, ra, rb;
        logic [63:0] prod;
        bit          stall_ok, seen;

        vecs[0]  = '{2'b10, 6'b100100, 4'b0000, 1'b0};
        vecs[1]  = '{2'b10, 6'b100111, 4'b1100, 1'b0};
        vecs[2]  = '{2'b10, 6'b101011, 4'b1000, 1'b0};
        vecs[3]  = '{2'b10, 6'b111111, 4'b1111, 1'b1};
        vecs[4]  = '{2'b00, 6'b111111, 4'b0010, 1'b0};
        vecs[5]  = '{2'b01, 6'b100100, 4'b0110, 1'b0};
        vecs[6]  = '{2'b10, 6'b100001, 4'b0010, 1'b0};
        vecs[7]  = '{2'b11, 6'b100011, 4'b0110, 1'b0};
        vecs[8]  = '{2'b10, 6'b100101, 4'b0001, 1'b0};
        vecs[9]  = '{2'b10, 6'b100110, 4'b0011, 1'b0};
        vecs[10] = '{2'b10, 6'b101010, 4'b0111, 1'b0};
        vecs[11] = '{2'b10, 6'b011011, 4'b0010, 1'b0};
        vecs[12] = '{2'b11, 6'b010010, 4'b0010, 1'b0};
        vecs[13] = '{2'b10, 6'b010100, 4'b1111, 1'b1};

        rst_n = 1'b0; valid = 1'b0; alu_op = 2'b00; instr_funct = '0;
        flush = 1'b0; src_a = '0; src_b = '0;
        #12;
        chk("reset hi", 64'(hi), 64'd0);
        chk("reset lo", 64'(lo), 64'd0);
        chk("reset busy", 64'(md_busy), 64'd0);
        chk("reset done", 64'(md_done), 64'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            alu_op = vecs[i].op; instr_funct = vecs[i].funct;
            #1;
            chk($sformatf("decode[%0d] ctrl", i), 64'(alu_control), 64'(vecs[i].exp_ctrl));
            chk($sformatf("decode[%0d] illegal", i), 64'(illegal_funct), 64'(vecs[i].exp_ill));
        end
        @(posedge clk); #1;

        // mthi / mtlo while idle, then mfhi / mflo readback
        valid = 1'b1; alu_op = 2'b10; instr_funct = 6'b010001; src_a = 32'hA5A5A5A5;
        @(posedge clk); #1;
        chk("mthi hi", 64'(hi), 64'hA5A5A5A5);
        instr_funct = 6'b010011; src_a = 32'h5A5A0000;
        @(posedge clk); #1;
        valid = 1'b0;
        chk("mtlo lo", 64'(lo), 64'h5A5A0000);
        chk("mtlo keeps hi", 64'(hi), 64'hA5A5A5A5);
        instr_funct = 6'b010000; #1;
        chk("mfhi result", 64'(md_result), 64'hA5A5A5A5);
        instr_funct = 6'b010010; #1;
        chk("mflo result", 64'(md_result), 64'h5A5A0000);
        instr_funct = 6'b100000; #1;
        chk("non-md result", 64'(md_result), 64'd0);

        run_md(6'b011001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, "multu max");
        run_md(6'b011000, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, "mult -3x5");
        run_md(6'b011010, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, "div -7/2");
        run_md(6'b011011, 32'd100, 32'd7, 32'd2, 32'd14, "divu 100/7");
        run_md(6'b011010, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, "div minneg/-1");
        run_md(6'b011011, 32'h00001234, 32'd0, 32'h00001234, 32'hFFFFFFFF, "divu by zero");
        run_md(6'b011010, 32'hFFFFFFF0, 32'd0, 32'hFFFFFFF0, 32'hFFFFFFFF, "div by zero neg");

        ra = $urandom; rb = $urandom;
        prod = {32'd0, ra} * {32'd0, rb};
        run_md(6'b011001, ra, rb, prod[63:32], prod[31:0], "multu random");
        ra = $urandom; rb = 32'($urandom_range(1, 1000));
        run_md(6'b011011, ra, rb, ra % rb, ra / rb, "divu random");

        // mflo held two cycles after mult must stall until the result lands
        begin
            exp_t e;
            e.hi = 32'hFFFFFFFF; e.lo = 32'hFFFFFFF1; e.name = "mult stall";
            valid = 1'b1; alu_op = 2'b10; instr_funct = 6'b011000;
            src_a = 32'hFFFFFFFD; src_b = 32'd5;
            sb.push_back(e);
            @(posedge clk); #1;
            valid = 1'b0;
            @(posedge clk); #1;
            valid = 1'b1; instr_funct = 6'b010010; #1;
            stall_ok = 1'b1; seen = 1'b0;
            for (int i = 0; i < 100; i++) begin
                if (md_done) begin
                    seen = 1'b1;
                    break;
                end
                if (!md_stall) stall_ok = 1'b0;
                @(posedge clk); #1;
            end
            chk("mflo stall done seen", 64'(seen), 64'd1);
            chk("mflo stall held", 64'(stall_ok), 64'd1);
            chk("mflo stall released", 64'(md_stall), 64'd0);
            chk("mflo new lo", 64'(md_result), 64'hFFFFFFF1);
            if (seen) pop_check();
            else void'(sb.pop_back());
            valid = 1'b0;
            @(posedge clk); #1;
        end

        // flush at iterate cycle 10
        old_hi = hi; old_lo = lo;
        valid = 1'b1; alu_op = 2'b10; instr_funct = 6'b011011; src_a = 32'd1000; src_b = 32'd3;
        @(posedge clk); #1;
        valid = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
        end
        chk("flush pre busy", 64'(md_busy), 64'd1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush busy", 64'(md_busy), 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (md_done || md_busy) seen = 1'b1;
            @(posedge clk); #1;
        end
        chk("flush no done", 64'(seen), 64'd0);
        chk("flush hi kept", 64'(hi), 64'(old_hi));
        chk("flush lo kept", 64'(lo), 64'(old_lo));

        // flush alongside accept suppresses the accept
        valid = 1'b1; instr_funct = 6'b011000; src_a = 32'd9; src_b = 32'd9; flush = 1'b1;
        @(posedge clk); #1;
        valid = 1'b0; flush = 1'b0;
        chk("flush+accept busy", 64'(md_busy), 64'd0);
        valid = 1'b1; instr_funct = 6'b010001; src_a = 32'h13572468; flush = 1'b1;
        @(posedge clk); #1;
        valid = 1'b0; flush = 1'b0;
        chk("flush+mthi hi kept", 64'(hi), 64'(old_hi));

        // asynchronous reset in the middle of a divide
        valid = 1'b1; instr_funct = 6'b011010; src_a = 32'h7FFFFFFF; src_b = 32'd3;
        @(posedge clk); #1;
        valid = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
        end
        #2 rst_n = 1'b0;
        #1;
        chk("midreset busy", 64'(md_busy), 64'd0);
        chk("midreset hi", 64'(hi), 64'd0);
        chk("midreset lo", 64'(lo), 64'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        run_md(6'b011011, 32'd50, 32'd6, 32'd2, 32'd8, "divu after reset");

        chk("scoreboard drained", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_alu_ctrl_md.md
# mips_alu_ctrl_md

Parametrised EX-stage control block for the MIPS core: decodes ALUOp/funct into a 4-bit ALU control word covering the full R-type arithmetic/logic set, and owns the HI/LO register pair with an iterative multiply/divide sequencer. It sits between the main decoder and the ALU/datapath. It drives a stall to the pipeline while a multiply or divide is in flight.

## Interface
- WIDTH, 32, datapath and HI/LO width (≥ 4).
- CTRL_W, 4, ALU control word width (fixed encodings defined in the package).
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- valid  in  1  EX-stage instruction valid this cycle
- alu_op  in  2  main-decoder ALUOp
- instr_funct  in  6  instruction funct field
- flush  in  1  kill in-flight mul/div (pipeline flush)
- src_a, src_b  in  WIDTH  operands (rs, rt)
- alu_control  out  CTRL_W  combinational ALU select
- illegal_funct  out  1  R-type funct not recognised
- md_result  out  WIDTH  HI or LO for mfhi/mflo (combinational)
- md_stall  out  1  hold EX: HI/LO access while busy
- md_busy  out  1  sequencer active
- md_done  out  1  one-cycle pulse, HI/LO just updated
- hi, lo  out  WIDTH  architectural HI/LO

## Operation
- Decode, priority order: alu_op=00 → ADD 0010; alu_op=01 → SUB 0110; alu_op=1x → by funct: 100000/100001 ADD 0010, 100010/100011 SUB 0110, 100100 AND 0000, 100101 OR 0001, 100110 XOR 0011, 100111 NOR 1100, 101010 SLT 0111, 101011 SLTU 1000.
- Mul/div functs (alu_op=1x only): 011000 mult, 011001 multu, 011010 div, 011011 divu, 010000 mfhi, 010010 mflo, 010001 mthi, 010011 mtlo; these give alu_control=0010, illegal_funct=0.
- Any other funct with alu_op=1x: alu_control=1111, illegal_funct=1.
- md-class = alu_op[1] & funct in the mul/div set. md_stall = valid & md-class & md_busy.
- Accept = valid & md-class & ~md_busy & ~flush. mthi/mtlo write src_a into HI/LO on the accept edge. mfhi/mflo drive md_result=HI/LO; otherwise md_result=0.
- FSM states: IDLE, MUL, DIV, FIXUP.
  - IDLE→MUL/DIV on mult*/div* accept. Operands are latched as magnitudes (signed ops); result sign and dividend sign are recorded.
  - MUL: shift-add, 1 bit/cycle. DIV: restoring, 1 bit/cycle. Both run exactly WIDTH cycles, counter 0..WIDTH-1, then → FIXUP.
  - FIXUP: apply sign correction (quotient sign = sign_a^sign_b; remainder sign = sign_a), write HI/LO, → IDLE.
- Product is 2·WIDTH bits: HI=upper, LO=lower. Division: LO=quotient, HI=remainder.
- Divide by zero (signed or unsigned): LO = all ones, HI = latched src_a, same latency.
- div of most-negative by −1: LO = most-negative, HI = 0. No exception.
- flush: in any non-IDLE state → IDLE on next edge; HI/LO unchanged, no md_done. Flush in the same cycle as an accept suppresses the accept.

## Timing
- Reset (async, rst_n=0): state IDLE, counter 0, hi=lo=0, md_busy=0, md_done=0; a reset mid-operation discards it.
- alu_control, illegal_funct, md_result, md_stall: combinational, zero latency.
- mult*/div* accepted on edge E0. md_busy is high from the cycle after E0 for WIDTH+1 cycles (WIDTH iterate + 1 FIXUP). HI/LO update on edge E0+WIDTH+1.
- In the first cycle after that edge: md_done=1 (registered), md_busy=0, and a held mfhi reads the new value. A new op may be accepted in that cycle.
- mthi/mtlo: HI/LO visible the cycle after the accept edge.

## Structure
- Package mips_alu_pkg holds: the ALU control encoding enum (CTRL_W bits, incl. ALU_INVALID=1111), funct constants, and the md FSM state enum.
- Sub-module mips_muldiv_seq holds the FSM, counter, shift/accumulate registers and sign fixup, and owns HI/LO. The top holds decode, md-class/stall logic and the mthi/mtlo/mfhi/mflo muxing.

## Test plan
- Decode sweep: alu_op=10 with funct 100100 → 0000, 100111 → 1100, 101011 → 1000, 111111 → 1111 with illegal_funct=1; alu_op=00 with any funct → 0010; alu_op=01 → 0110.
- multu 0xFFFFFFFF × 0xFFFFFFFF: md_busy for 33 cycles, then md_done with HI=0xFFFFFFFE, LO=0x00000001. mult −3 × 5 → HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- div −7 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu 100 / 7 → LO=14, HI=2. div 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- divu 0x1234 / 0 → LO=0xFFFFFFFF, HI=0x1234 after 33 busy cycles.
- mflo issued 2 cycles after mult: md_stall=1 until md_done, then md_result equals the new LO. mthi 0xA5A5A5A5 while idle → hi=0xA5A5A5A5 next cycle.
- Flush at iterate cycle 10: IDLE next cycle, HI/LO keep their old values, no md_done. rst_n low mid-div: immediate IDLE, hi=lo=0.
